decoder_sequencer: RTL

Sequencer that drives the board's 3-to-8 one-hot LED decoder. It steps a 3-bit index through 0..7 at a programmable rate and decodes it to active-low one-hot `out_n`. Three debounced active-low keys control it:
- pause/run,
- direction,
- wrap versus bounce ("ping-pong") mode.

It sits between the board keys and the LED row, replacing the direct key-to-decoder connection with a timed, user-configurable scan.

---
 rtl/decoder_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/decoder_sequencer.sv
// Timed 3-to-8 LED scan: debounced keys toggle run/direction/bounce; index steps every STEP_DIV cycles.
// Key press reaches state DEBOUNCE_CYCLES+3 edges after sampling; out_n is combinational from index; no backpressure.
module decoder_sequencer #(
    parameter int STEP_DIV        = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] key_n,
    output logic [2:0] index,
    output logic [7:0] out_n,
    output logic       run,
    output logic       dir,
    output logic       bounce
);
    localparam int PW = $clog2(STEP_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PS_MAX = PW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]          sync1_q;
    logic [2:0]          key_s_q;
    logic [2:0]          key_db_q, key_db_d;
    logic [2:0]          press_q, press_d;
    logic [2:0][DW-1:0]  db_cnt_q, db_cnt_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [2:0]          index_q, index_d;
    logic                run_q, run_d;
    logic                dir_q, dir_d;
    logic                bounce_q, bounce_d;
    logic                run_e, dir_e, bounce_e;
    logic                step;

    // A new level is accepted only after it has differed from key_db for DEBOUNCE_CYCLES edges.
    always_comb begin
        key_db_d = key_db_q;
        press_d  = '0;
        db_cnt_d = '0;
        for (int k = 0; k < 3; k++) begin
            if (key_s_q[k] != key_db_q[k]) begin
                if (db_cnt_q[k] == DB_MAX) begin
                    key_db_d[k] = key_s_q[k];
                    press_d[k]  = ~key_s_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        run_e    = run_q ^ press_q[0];
        dir_e    = dir_q ^ press_q[1];
        bounce_e = bounce_q ^ press_q[2];

        presc_d  = presc_q;
        step     = 1'b0;
        run_d    = run_e;
        dir_d    = dir_e;
        bounce_d = bounce_e;
        index_d  = index_q;

        // Pausing holds the count, so a pause at terminal count steps on the resume edge.
        if (run_e) begin
            if (presc_q == PS_MAX) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (step) begin
            if (bounce_e && !dir_e && index_q == 3'd7) begin
                dir_d   = 1'b1;
                index_d = 3'd6;
            end else if (bounce_e && dir_e && index_q == 3'd0) begin
                dir_d   = 1'b0;
                index_d = 3'd1;
            end else if (dir_e) begin
                index_d = index_q - 3'd1;
            end else begin
                index_d = index_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '1;
            key_s_q  <= '1;
            key_db_q <= '1;
            press_q  <= '0;
            db_cnt_q <= '0;
            presc_q  <= '0;
            index_q  <= '0;
            run_q    <= 1'b1;
            dir_q    <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            key_s_q  <= sync1_q;
            key_db_q <= key_db_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
            presc_q  <= presc_d;
            index_q  <= index_d;
            run_q    <= run_d;
            dir_q    <= dir_d;
            bounce_q <= bounce_d;
        end
    end

    assign index  = index_q;
    assign out_n  = ~(8'b1 << index_q);
    assign run    = run_q;
    assign dir    = dir_q;
    assign bounce = bounce_q;

endmodule
